// File: rtl/morse_playback_engine.sv
// Morse playback engine: a packet FIFO feeding an ITU-timed tone/dash envelope player.
// Optional define MORSE_PB_FARNSWORTH_EN: character and word gaps always use the level-0 unit.
`timescale 1ns/1ps
module morse_playback_engine #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int MAX_SYM      = 8,
    parameter int FIFO_DEPTH   = 8,
    parameter int N_LEVELS     = 5,
    parameter int UNIT_MS_BASE = 120,
    parameter int UNIT_MS_STEP = 20
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            is_active,
    input  logic                            speed_up,
    input  logic                            speed_down,
    output logic [$clog2(N_LEVELS)-1:0]     speed_level,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [$clog2(MAX_SYM+1)-1:0]    in_len,
    input  logic [MAX_SYM-1:0]              in_pattern,
    input  logic                            flush,
    output logic                            tone_on,
    output logic                            dash_active,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);
    localparam int LENW = $clog2(MAX_SYM + 1);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int LW   = $clog2(N_LEVELS);
    localparam logic [31:0] KHZ = 32'(CLK_HZ / 1000);

    typedef enum logic [2:0] {IDLE, LOAD, ELEM_ON, ELEM_GAP, CHAR_GAP, WORD_GAP} state_t;

    state_t             state;
    logic [31:0]        cnt, unit_cycles, unit_now, char_gap_len, word_gap_len, head_first_len;
    logic [LENW-1:0]    len_mem [FIFO_DEPTH];
    logic [MAX_SYM-1:0] pat_mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [LENW-1:0]    head_len, wr_len, elem_left;
    logic [MAX_SYM-1:0] head_pat, shift_reg, shift_next;
    logic               ready_en, push, pop, gap_done;

    // Packet handshake: a packet transfers on every rising edge where in_valid && in_ready;
    // in_valid may be held across stalls, in_ready never depends on in_valid, and flush blocks the write.
    assign in_ready = ready_en && (fifo_count < CW'(FIFO_DEPTH)) && !flush;
    assign push     = in_valid && in_ready;
    assign gap_done = is_active && (state == CHAR_GAP || state == WORD_GAP) && (cnt == 32'd1);
    // The end of a gap pops the next packet directly so back-to-back packets add no idle cycles.
    assign pop      = !flush && (fifo_count != '0) && ((is_active && state == IDLE) || gap_done);
    assign busy     = (state != IDLE) || (fifo_count != '0);

    assign head_len       = len_mem[rd_ptr];
    assign head_pat       = pat_mem[rd_ptr];
    assign wr_len         = (in_len > LENW'(MAX_SYM)) ? LENW'(MAX_SYM) : in_len;
    assign shift_next     = shift_reg >> 1;
    assign unit_now       = KHZ * (32'(UNIT_MS_BASE) - 32'(UNIT_MS_STEP) * 32'(speed_level));
    assign head_first_len = head_pat[0] ? unit_now * 32'd3 : unit_now;

`ifdef MORSE_PB_FARNSWORTH_EN
    localparam logic [31:0] BASE_UNIT = KHZ * 32'(UNIT_MS_BASE);
    assign char_gap_len = BASE_UNIT * 32'd3;
    assign word_gap_len = BASE_UNIT * 32'd7;
`else
    assign char_gap_len = unit_cycles * 32'd3;
    assign word_gap_len = unit_now * 32'd7;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            len_mem[wr_ptr] <= wr_len;
            pat_mem[wr_ptr] <= in_pattern;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            ready_en <= 1'b1;
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speed_level <= '0;
        end else if (speed_up && !speed_down && speed_level < LW'(N_LEVELS - 1)) begin
            speed_level <= speed_level + LW'(1);
        end else if (speed_down && !speed_up && speed_level != '0) begin
            speed_level <= speed_level - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            unit_cycles <= '0;
            shift_reg   <= '0;
            elem_left   <= '0;
            tone_on     <= 1'b0;
            dash_active <= 1'b0;
        end else if (flush) begin
            state       <= IDLE;
            cnt         <= '0;
            tone_on     <= 1'b0;
            dash_active <= 1'b0;
        end else if (!is_active) begin
            tone_on     <= 1'b0;
            dash_active <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_count != '0) begin
                        shift_reg <= head_pat;
                        elem_left <= head_len;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    unit_cycles <= unit_now;
                    if (elem_left == '0) begin
                        state <= WORD_GAP;
                        cnt   <= word_gap_len;
                    end else begin
                        state       <= ELEM_ON;
                        cnt         <= shift_reg[0] ? unit_now * 32'd3 : unit_now;
                        tone_on     <= 1'b1;
                        dash_active <= shift_reg[0];
                    end
                end
                ELEM_ON: begin
                    if (cnt == 32'd1) begin
                        tone_on     <= 1'b0;
                        dash_active <= 1'b0;
                        if (elem_left > LENW'(1)) begin
                            state       <= ELEM_GAP;
                            unit_cycles <= unit_now;
                            cnt         <= unit_now;
                            elem_left   <= elem_left - LENW'(1);
                        end else begin
                            state <= CHAR_GAP;
                            cnt   <= char_gap_len;
                        end
                    end else begin
                        // Re-asserted every cycle so a resumed element sounds again after a pause.
                        cnt         <= cnt - 32'd1;
                        tone_on     <= 1'b1;
                        dash_active <= shift_reg[0];
                    end
                end
                ELEM_GAP: begin
                    if (cnt == 32'd1) begin
                        shift_reg   <= shift_next;
                        state       <= ELEM_ON;
                        cnt         <= shift_next[0] ? unit_cycles * 32'd3 : unit_cycles;
                        tone_on     <= 1'b1;
                        dash_active <= shift_next[0];
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                CHAR_GAP, WORD_GAP: begin
                    if (cnt != 32'd1) begin
                        cnt <= cnt - 32'd1;
                    end else if (fifo_count == '0) begin
                        state <= IDLE;
                    end else begin
                        unit_cycles <= unit_now;
                        shift_reg   <= head_pat;
                        elem_left   <= head_len;
                        if (head_len == '0) begin
                            state <= WORD_GAP;
                            cnt   <= word_gap_len;
                        end else begin
                            state       <= ELEM_ON;
                            cnt         <= head_first_len;
                            tone_on     <= 1'b1;
                            dash_active <= head_pat[0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_morse_playback_engine.sv
// Directed bench for morse_playback_engine at CLK_HZ=10_000 (level-0 unit = 1200 cycles).
`timescale 1ns/1ps
module tb_morse_playback_engine;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       is_active = 1'b1;
  logic       speed_up = 1'b0;
  logic       speed_down = 1'b0;
  logic [2:0] speed_level;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_len = '0;
  logic [7:0] in_pattern = '0;
  logic       flush = 1'b0;
  logic       tone_on;
  logic       dash_active;
  logic       busy;
  logic [3:0] fifo_count;

  int checks = 0;
  int errors = 0;

`ifdef MORSE_PB_FARNSWORTH_EN
  localparam int GAP_L2 = 3600;
  localparam int GAP_L4 = 3600;
`else
  localparam int GAP_L2 = 2400;
  localparam int GAP_L4 = 1200;
`endif

  morse_playback_engine #(.CLK_HZ(10_000)) dut (
    .clk(clk), .rst_n(rst_n), .is_active(is_active), .speed_up(speed_up),
    .speed_down(speed_down), .speed_level(speed_level), .in_valid(in_valid),
    .in_ready(in_ready), .in_len(in_len), .in_pattern(in_pattern), .flush(flush),
    .tone_on(tone_on), .dash_active(dash_active), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Offer one packet; returns just after the accepting edge.
  task automatic push(input logic [3:0] len, input logic [7:0] pat);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_len = len; in_pattern = pat;
    while (!in_ready && n < 20000) begin @(negedge clk); n++; end
    checks++;
    if (n >= 20000) begin errors++; $display("FAIL push_ready: waited %0d cycles, limit 20000", n); end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count negedge samples until the selected signal (0 tone, 1 busy) equals val; -1 on timeout.
  task automatic wait_sig(input int sel, input logic val, input int max_cyc, output int n);
    logic s;
    n = 0;
    do begin
      @(negedge clk); n++;
      s = (sel == 0) ? tone_on : busy;
    end while (s !== val && n < max_cyc);
    if (s !== val) n = -1;
  endtask

  task automatic pulse(input logic up, input logic dn, input int times);
    for (int i = 0; i < times; i++) begin
      @(negedge clk); speed_up = up; speed_down = dn;
      @(negedge clk); speed_up = 1'b0; speed_down = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if ({tone_on, dash_active, busy, in_ready} !== 4'b0) begin errors++; $display("FAIL reset_outs: got %b expected 0000", {tone_on, dash_active, busy, in_ready}); end
    checks++; if (fifo_count !== 4'd0 || speed_level !== 3'd0) begin errors++; $display("FAIL reset_regs: count %0d level %0d expected 0 0", fifo_count, speed_level); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_early: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_rise: got %b expected 1", in_ready); end
  endtask

  task automatic test_single_e();
    int n;
    push(4'd1, 8'h00);
    wait_sig(0, 1'b1, 10, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL e_rise: got %0d expected 3", n); end
    checks++; if (dash_active !== 1'b0) begin errors++; $display("FAIL e_dash: got %b expected 0", dash_active); end
    wait_sig(0, 1'b0, 5000, n);
    checks++; if (n !== 1200) begin errors++; $display("FAIL e_high: got %0d expected 1200", n); end
    wait_sig(1, 1'b0, 10000, n);
    checks++; if (n !== 3600) begin errors++; $display("FAIL e_char_gap: got %0d expected 3600", n); end
  endtask

  task automatic test_letter_a();
    int n;
    push(4'd2, 8'b10);
    wait_sig(0, 1'b1, 10, n);
    checks++; if (n !== 3 || dash_active !== 1'b0) begin errors++; $display("FAIL a_rise: got %0d dash %b expected 3 dash 0", n, dash_active); end
    wait_sig(0, 1'b0, 5000, n);
    checks++; if (n !== 1200) begin errors++; $display("FAIL a_dot: got %0d expected 1200", n); end
    wait_sig(0, 1'b1, 5000, n);
    checks++; if (n !== 1200) begin errors++; $display("FAIL a_elem_gap: got %0d expected 1200", n); end
    checks++; if (dash_active !== 1'b1) begin errors++; $display("FAIL a_dash_flag: got %b expected 1", dash_active); end
    wait_sig(0, 1'b0, 10000, n);
    checks++; if (n !== 3600 || dash_active !== 1'b0) begin errors++; $display("FAIL a_dash: got %0d dash %b expected 3600 dash 0", n, dash_active); end
    wait_sig(1, 1'b0, 10000, n);
    checks++; if (n !== 3600) begin errors++; $display("FAIL a_char_gap: got %0d expected 3600", n); end
  endtask

  task automatic test_back_to_back();
    int n;
    push(4'd1, 8'h00);
    push(4'd0, 8'h00);
    push(4'd1, 8'h00);
    wait_sig(0, 1'b1, 10, n);
    wait_sig(0, 1'b0, 5000, n);
    checks++; if (n !== 1200) begin errors++; $display("FAIL b2b_first: got %0d expected 1200", n); end
    wait_sig(0, 1'b1, 20000, n);
    checks++; if (n !== 12000) begin errors++; $display("FAIL b2b_word_gap: got %0d expected 12000", n); end
    wait_sig(0, 1'b0, 5000, n);
    checks++; if (n !== 1200) begin errors++; $display("FAIL b2b_second: got %0d expected 1200", n); end
    wait_sig(1, 1'b0, 10000, n);
    checks++; if (n !== 3600) begin errors++; $display("FAIL b2b_tail: got %0d expected 3600", n); end
  endtask

  task automatic test_speed();
    int n;
    pulse(1'b1, 1'b0, 2);
    checks++; if (speed_level !== 3'd2) begin errors++; $display("FAIL speed_l2: got %0d expected 2", speed_level); end
    push(4'd1, 8'h00);
    wait_sig(0, 1'b1, 10, n);
    wait_sig(0, 1'b0, 5000, n);
    checks++; if (n !== 800) begin errors++; $display("FAIL speed_dot_l2: got %0d expected 800", n); end
    wait_sig(1, 1'b0, 10000, n);
    checks++; if (n !== GAP_L2) begin errors++; $display("FAIL speed_gap_l2: got %0d expected %0d", n, GAP_L2); end
    pulse(1'b1, 1'b0, 10);
    checks++; if (speed_level !== 3'd4) begin errors++; $display("FAIL speed_sat_hi: got %0d expected 4", speed_level); end
    push(4'd1, 8'h00);
    wait_sig(0, 1'b1, 10, n);
    wait_sig(0, 1'b0, 5000, n);
    checks++; if (n !== 400) begin errors++; $display("FAIL speed_dot_l4: got %0d expected 400", n); end
    wait_sig(1, 1'b0, 10000, n);
    checks++; if (n !== GAP_L4) begin errors++; $display("FAIL speed_gap_l4: got %0d expected %0d", n, GAP_L4); end
    pulse(1'b1, 1'b1, 1);
    checks++; if (speed_level !== 3'd4) begin errors++; $display("FAIL speed_both: got %0d expected 4", speed_level); end
  endtask

  task automatic test_clamp();
    int n, high, rises;
    logic prev;
    push(4'd9, 8'h01);
    high = 0; rises = 0; prev = 1'b0; n = 0;
    do begin
      @(negedge clk); n++;
      if (tone_on === 1'b1) high++;
      if (tone_on === 1'b1 && prev === 1'b0) rises++;
      prev = tone_on;
    end while (busy && n < 30000);
    checks++; if (rises !== 8) begin errors++; $display("FAIL clamp_elems: got %0d expected 8", rises); end
    checks++; if (high !== 4000) begin errors++; $display("FAIL clamp_high: got %0d expected 4000", high); end
    pulse(1'b0, 1'b1, 10);
    checks++; if (speed_level !== 3'd0) begin errors++; $display("FAIL speed_sat_lo: got %0d expected 0", speed_level); end
  endtask

  task automatic test_pause();
    int n, high, paused_high;
    push(4'd1, 8'h00);
    wait_sig(0, 1'b1, 10, n);
    high = 1;
    repeat (299) begin @(negedge clk); if (tone_on === 1'b1) high++; end
    is_active = 1'b0;
    paused_high = 0;
    repeat (500) begin @(negedge clk); if (tone_on === 1'b1) paused_high++; end
    checks++; if (paused_high !== 0) begin errors++; $display("FAIL pause_tone: got %0d high cycles expected 0", paused_high); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pause_busy: got %b expected 1", busy); end
    is_active = 1'b1;
    n = 0;
    while (busy && n < 20000) begin @(negedge clk); n++; if (tone_on === 1'b1) high++; end
    checks++; if (high !== 1200) begin errors++; $display("FAIL pause_total: got %0d expected 1200", high); end
  endtask

  task automatic test_fill_flush_write();
    @(negedge clk);
    is_active = 1'b0; in_valid = 1'b1; in_len = 4'd1; in_pattern = 8'h00;
    repeat (8) @(negedge clk);
    checks++; if (fifo_count !== 4'd8 || in_ready !== 1'b0) begin errors++; $display("FAIL fill_full: count %0d ready %b expected 8 0", fifo_count, in_ready); end
    repeat (3) @(negedge clk);
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL fill_hold: got %0d expected 8", fifo_count); end
    is_active = 1'b1;
    @(negedge clk);
    checks++; if (fifo_count !== 4'd7 || in_ready !== 1'b1) begin errors++; $display("FAIL fill_pop: count %0d ready %b expected 7 1", fifo_count, in_ready); end
    @(negedge clk);
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL fill_ninth: got %0d expected 8", fifo_count); end
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    flush = 1'b1; in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (fifo_count !== 4'd0 || busy !== 1'b0 || tone_on !== 1'b0) begin errors++; $display("FAIL flush_write: count %0d busy %b tone %b expected 0 0 0", fifo_count, busy, tone_on); end
  endtask

  task automatic test_flush_mid_dash();
    int n;
    push(4'd1, 8'h01);
    push(4'd1, 8'h00);
    push(4'd2, 8'h02);
    push(4'd0, 8'h00);
    wait_sig(0, 1'b1, 10, n);
    repeat (100) @(negedge clk);
    checks++; if (dash_active !== 1'b1 || fifo_count !== 4'd3) begin errors++; $display("FAIL flush_pre: dash %b count %0d expected 1 3", dash_active, fifo_count); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checks++; if ({tone_on, dash_active, busy} !== 3'b000 || fifo_count !== 4'd0) begin errors++; $display("FAIL flush_mid: tone/dash/busy %b count %0d expected 000 0", {tone_on, dash_active, busy}, fifo_count); end
    repeat (10) @(negedge clk);
    checks++; if (tone_on !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_stay_idle: tone %b busy %b expected 0 0", tone_on, busy); end
  endtask

  task automatic test_async_reset();
    int n;
    pulse(1'b1, 1'b0, 1);
    push(4'd1, 8'h01);
    push(4'd1, 8'h00);
    wait_sig(0, 1'b1, 10, n);
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({tone_on, dash_active, busy, in_ready} !== 4'b0) begin errors++; $display("FAIL areset_outs: got %b expected 0000", {tone_on, dash_active, busy, in_ready}); end
    checks++; if (fifo_count !== 4'd0 || speed_level !== 3'd0) begin errors++; $display("FAIL areset_regs: count %0d level %0d expected 0 0", fifo_count, speed_level); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL areset_release: ready %b busy %b expected 1 0", in_ready, busy); end
  endtask

  initial begin
    test_reset();
    test_single_e();
    test_letter_a();
    test_back_to_back();
    test_speed();
    test_clamp();
    test_pause();
    test_fill_flush_write();
    test_flush_mid_dash();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
